sysid_boot_checker: RTL

SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

---
 rtl/sysid_boot_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid checker: reads ID and timestamp words from an Avalon-MM
// sysid slave and flags whether they match. Optional macro: SYSID_CHK_RECHECK_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1619177237,
    parameter int unsigned TIMEOUT        = 16,
    parameter int unsigned RECHECK_PERIOD = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // Reject parameter values the counters cannot represent.
    if (TIMEOUT < 1 || TIMEOUT > 255 || RECHECK_PERIOD < 1) begin : g_bad_param
        $error("sysid_boot_checker: TIMEOUT must be 1..255, RECHECK_PERIOD >= 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_tmo_cnt;
    logic        w_in_read;
    logic        w_tmo_hit;
    logic        w_rc_hit;

    assign w_in_read = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_tmo_hit = w_in_read && m_waitrequest && (r_tmo_cnt == TMO_LAST);

`ifdef SYSID_CHK_RECHECK_EN
    localparam int RC_W = (RECHECK_PERIOD > 1) ? $clog2(RECHECK_PERIOD) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECHECK_PERIOD - 1);

    logic [RC_W-1:0] r_rc_cnt;

    assign w_rc_hit = (r_state == S_DONE) && (r_rc_cnt == RC_LAST);

    // Count cycles spent in DONE; any exit or a manual start clears it.
    always_ff @(posedge clock) begin
        if (reset || r_state != S_DONE || start) begin
            r_rc_cnt <= '0;
        end else begin
            r_rc_cnt <= r_rc_cnt + 1'b1;
        end
    end
`else
    assign w_rc_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a stalled read gives up once the budget runs out.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: w_next = S_RD_ID;
            S_RD_ID: begin
                if (!m_waitrequest) begin
                    w_next = S_RD_TS;
                end else if (w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_RD_TS: begin
                if (!m_waitrequest) begin
                    w_next = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_CHECK: w_next = S_DONE;
            S_DONE: begin
                if (start || w_rc_hit) begin
                    w_next = S_RD_ID;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Per-read stall counter, cleared whenever the state changes.
    always_ff @(posedge clock) begin
        if (reset || w_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if (w_in_read && m_waitrequest) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Capture read data and load result flags; they hold during a re-run.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_value    <= '0;
            ts_value    <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (r_state == S_RD_ID && !m_waitrequest) begin
                id_value <= m_readdata;
            end
            if (r_state == S_RD_TS && !m_waitrequest) begin
                ts_value <= m_readdata;
            end
            if (r_state == S_CHECK) begin
                id_ok       <= (id_value == EXPECTED_ID);
                ts_ok       <= (ts_value == EXPECTED_TS);
                timeout_err <= 1'b0;
            end else if (w_tmo_hit) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b1;
            end
        end
    end

    assign m_read    = w_in_read;
    assign m_address = (r_state == S_RD_TS);
    assign busy      = w_in_read || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);

endmodule
